// File: rtl/chess_keycode_event_ctrl.sv
// -----------------------------------------------------------------------------
// chess_keycode_event_ctrl
//   Avalon-MM slave sitting between the NIOS USB-keyboard driver and the chess
//   game FSM. Software writes the currently held keycode; level changes become
//   press events, and a held key produces typematic repeat events. Events are
//   queued in a show-ahead FIFO and drained over a valid/ready handshake.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   address[1:0]          0=KEY, 1=STATUS, 2=CTRL, 3=reserved
//   chipselect, write_n   slave select, active-low write strobe
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read data
//   evt_valid/evt_key/evt_repeat   FIFO head event (zeros when empty)
//   evt_ready             consumer accepts head event
//   held_key[7:0]         currently held keycode (0 = none)
//
// Repeat FSM
//   state     | meaning
//   ST_IDLE   | no key held or repeat disabled; timer frozen
//   ST_DELAY  | counting down to the first repeat after a press
//   ST_REPEAT | counting down between subsequent repeats
// -----------------------------------------------------------------------------
module chess_keycode_event_ctrl #(
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        evt_valid,
    output logic [7:0]  evt_key,
    output logic        evt_repeat,
    input  logic        evt_ready,
    output logic [7:0]  held_key
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [31:0]   C_DELAY_LD  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0]   C_PERIOD_LD = 32'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_timer;
    logic [7:0]    r_held_key;
    logic          r_repeat_en;
    logic          r_overflow;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_wr;
    logic          w_key_wr;
    logic          w_stat_wr;
    logic          w_ctrl_wr;
    logic [7:0]    w_new_key;
    logic          w_key_change;
    logic          w_press;
    logic          w_rep_fire;
    logic          w_push;
    logic [8:0]    w_push_data;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;
    logic [8:0]    w_head;
    logic          w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_key_wr  = w_wr & (address == 2'd0);
    assign w_stat_wr = w_wr & (address == 2'd1);
    assign w_ctrl_wr = w_wr & (address == 2'd2);
    assign w_new_key = writedata[7:0];
    assign w_unused  = ^writedata[31:8];

    // A KEY write that changes the held key owns this cycle: any repeat that
    // would have fired on the same edge is discarded.
    assign w_key_change = w_key_wr & (w_new_key != r_held_key);
    assign w_press      = w_key_change & (w_new_key != 8'd0);
    assign w_rep_fire   = (r_state != ST_IDLE) & r_repeat_en & (r_timer == 32'd0)
                          & ~w_key_change;
    assign w_push       = w_press | w_rep_fire;
    assign w_push_data  = w_press ? {1'b0, w_new_key} : {1'b1, r_held_key};

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_full    = (r_count == C_DEPTH);
    assign w_pop     = (r_count != '0) & evt_ready;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & ~w_push_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= 32'd0;
            r_held_key <= 8'd0;
        end else if (w_key_change) begin
            r_held_key <= w_new_key;
            if ((w_new_key != 8'd0) && r_repeat_en) begin
                r_state <= ST_DELAY;
                r_timer <= C_DELAY_LD;
            end else begin
                r_state <= ST_IDLE;
            end
        end else if (r_state != ST_IDLE) begin
            if (!r_repeat_en) begin
                r_state <= ST_IDLE;
            end else if (r_timer == 32'd0) begin
                r_state <= ST_REPEAT;
                r_timer <= C_PERIOD_LD;
            end else begin
                r_timer <= r_timer - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_repeat_en <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_repeat_en <= writedata[0];
            end
            // A drop on the same edge as a software clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_stat_wr & writedata[0]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    assign w_head     = (r_count != '0) ? r_mem[r_rptr] : 9'd0;
    assign evt_valid  = (r_count != '0);
    assign evt_key    = w_head[7:0];
    assign evt_repeat = w_head[8];
    assign held_key   = r_held_key;

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {24'd0, r_held_key};
            2'd1:    readdata = {16'd0, 8'(r_count), 6'd0, w_full, r_overflow};
            2'd2:    readdata = {31'd0, r_repeat_en};
            default: readdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_chess_keycode_event_ctrl.sv
// Bench for chess_keycode_event_ctrl with a small FIFO and short repeat timers.
// The reference model tracks the held key, an event queue and the absolute
// cycle of the next repeat, advanced once per clock edge.
module tb_chess_keycode_event_ctrl;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        evt_valid;
    logic [7:0]  evt_key;
    logic        evt_repeat;
    logic        evt_ready;
    logic [7:0]  held_key;

    always #5 clk = ~clk;

    chess_keycode_event_ctrl #(
        .FIFO_DEPTH(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .evt_valid(evt_valid), .evt_key(evt_key), .evt_repeat(evt_repeat),
        .evt_ready(evt_ready), .held_key(held_key)
    );

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] m_held;
    logic [8:0] m_q[$];
    bit         m_rep_active;
    int         m_next_rep;
    bit         m_repeat_en;
    bit         m_ovf;
    int         cyc;

    function automatic logic [17:0] exp_out();
        logic [8:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 9'd0;
        return {(m_q.size() != 0), h[7:0], h[8], m_held};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_held};
            2'd1:    return {16'd0, 8'(m_q.size()), 6'd0, (m_q.size() == D), m_ovf};
            2'd2:    return {31'd0, m_repeat_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_held = 8'd0;
        m_q.delete();
        m_rep_active = 0;
        m_next_rep = 0;
        m_repeat_en = 1;
        m_ovf = 0;
        cyc = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit wr, pop, have_push, drop;
        logic [8:0] pd;
        logic [7:0] v;
        wr = chipselect && !write_n;
        v = writedata[7:0];
        pop = (m_q.size() != 0) && evt_ready;
        have_push = 0;
        pd = 9'd0;
        if (wr && address == 2'd0 && v != m_held) begin
            m_held = v;
            if (v != 8'd0) begin
                have_push = 1;
                pd = {1'b0, v};
            end
            m_rep_active = (v != 8'd0) && m_repeat_en;
            m_next_rep = cyc + RD;
        end else if (m_rep_active && !m_repeat_en) begin
            m_rep_active = 0;
        end else if (m_rep_active && cyc == m_next_rep) begin
            have_push = 1;
            pd = {1'b1, m_held};
            m_next_rep = cyc + RP;
        end
        if (pop) void'(m_q.pop_front());
        drop = 0;
        if (have_push) begin
            if (m_q.size() < D) m_q.push_back(pd);
            else drop = 1;
        end
        if (wr && address == 2'd1 && writedata[0]) m_ovf = 0;
        if (drop) m_ovf = 1;
        if (wr && address == 2'd2) m_repeat_en = writedata[0];
        cyc++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a; writedata = 32'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_idle();
        evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if ({evt_valid, evt_key, evt_repeat, held_key} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outs got %h want %h", {evt_valid, evt_key, evt_repeat, held_key}, 18'd0);
        end
        address = 2'd1; #1; n_vec++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want %h", readdata, 32'd0); end
        address = 2'd2; #1; n_vec++;
        if (readdata !== 32'd1) begin n_fail++; $display("FAIL reset_ctrl got %h want %h", readdata, 32'd1); end
        address = 2'd3; #1; n_vec++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_addr3 got %h want %h", readdata, 32'd0); end
        address = 2'd0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_press();
        int reps[$];
        evt_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) bus_wr(2'd0, 32'h1C);
            else if (i == 20) bus_wr(2'd0, 32'h0);
            else bus_idle();
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL press_model i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
            if (i == 0) begin
                n_vec++;
                if ({evt_valid, evt_key, evt_repeat} !== {1'b1, 8'h1C, 1'b0}) begin
                    n_fail++;
                    $display("FAIL press_first got %h want %h", {evt_valid, evt_key, evt_repeat}, {1'b1, 8'h1C, 1'b0});
                end
            end
            if (evt_valid && evt_repeat) reps.push_back(i);
        end
        bus_idle();
        n_vec++;
        if (reps.size() != 3 || reps[0] != 10 || reps[1] != 14 || reps[2] != 18) begin
            n_fail++;
            $display("FAIL press_repeat_times got n=%0d first=%0d want n=3 at 10,14,18", reps.size(), (reps.size() > 0) ? reps[0] : -1);
        end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        for (int i = 0; i < 41; i++) begin
            if (i == 0) bus_wr(2'd0, 32'h1C);
            else if (i == 40) bus_wr(2'd0, 32'h0);
            else bus_idle();
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL ovf_model i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
        end
        bus_rd(2'd1); #1; n_vec++;
        if (readdata !== 32'h0000_0403) begin n_fail++; $display("FAIL ovf_status got %h want %h", readdata, 32'h0000_0403); end
        step();
        bus_wr(2'd1, 32'h1);
        step();
        bus_rd(2'd1); #1; n_vec++;
        if (readdata !== 32'h0000_0402) begin n_fail++; $display("FAIL ovf_cleared got %h want %h", readdata, 32'h0000_0402); end
        step();
        bus_idle();
        n_vec++;
        if ({evt_valid, evt_key, evt_repeat} !== {1'b1, 8'h1C, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_head got %h want %h", {evt_valid, evt_key, evt_repeat}, {1'b1, 8'h1C, 1'b0});
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL ovf_drain i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
        end
    endtask

    task automatic test_same_key();
        int first_rep = -1;
        int presses = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || i == 5) bus_wr(2'd0, 32'h1C);
            else bus_idle();
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL same_model i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
            if (evt_valid && !evt_repeat) presses++;
            if (evt_valid && evt_repeat && first_rep < 0) first_rep = i;
        end
        n_vec++;
        if (presses != 1 || first_rep != 10) begin
            n_fail++;
            $display("FAIL same_key got presses=%0d first_rep=%0d want 1 and 10", presses, first_rep);
        end
        bus_wr(2'd0, 32'h0);
        step();
        bus_idle();
        repeat (3) step();
    endtask

    task automatic test_override();
        int early_reps = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 0) bus_wr(2'd0, 32'h1C);
            else if (i == 10) bus_wr(2'd0, 32'h1D);
            else bus_idle();
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL ovr_model i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
            if (i < 20 && evt_valid && evt_repeat) early_reps++;
            if (i == 10) begin
                n_vec++;
                if ({evt_valid, evt_key, evt_repeat} !== {1'b1, 8'h1D, 1'b0}) begin
                    n_fail++;
                    $display("FAIL ovr_press got %h want %h", {evt_valid, evt_key, evt_repeat}, {1'b1, 8'h1D, 1'b0});
                end
            end
            if (i == 20) begin
                n_vec++;
                if ({evt_valid, evt_key, evt_repeat} !== {1'b1, 8'h1D, 1'b1}) begin
                    n_fail++;
                    $display("FAIL ovr_repeat got %h want %h", {evt_valid, evt_key, evt_repeat}, {1'b1, 8'h1D, 1'b1});
                end
            end
        end
        n_vec++;
        if (early_reps != 0) begin n_fail++; $display("FAIL ovr_no_early got %0d want 0", early_reps); end
        bus_wr(2'd0, 32'h0);
        step();
        bus_idle();
        repeat (3) step();
    endtask

    task automatic test_no_repeat();
        int events = 0;
        evt_ready = 1'b1;
        bus_wr(2'd2, 32'h0);
        step();
        for (int i = 0; i < 30; i++) begin
            if (i == 0) bus_wr(2'd0, 32'h29);
            else bus_idle();
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL norep_model i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
            if (evt_valid) events++;
        end
        n_vec++;
        if (events != 1) begin n_fail++; $display("FAIL norep_count got %0d want 1", events); end
        bus_wr(2'd0, 32'h0);
        step();
    endtask

    task automatic test_full_pop_push();
        evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_wr(2'd0, 32'h11 + 32'(k));
            step();
        end
        evt_ready = 1'b1;
        bus_wr(2'd0, 32'h15);
        step();
        evt_ready = 1'b0;
        bus_rd(2'd1); #1; n_vec++;
        if (readdata !== 32'h0000_0402) begin n_fail++; $display("FAIL fpp_status got %h want %h", readdata, 32'h0000_0402); end
        bus_idle();
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat} !== {1'b1, 8'h12 + 8'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL fpp_order k=%0d got %h want %h", k, {evt_valid, evt_key, evt_repeat}, {1'b1, 8'h12 + 8'(k), 1'b0});
            end
            step();
        end
        n_vec++;
        if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
            n_fail++;
            $display("FAIL fpp_end got %h want %h", {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
        end
        bus_wr(2'd0, 32'h0);
        step();
        bus_wr(2'd2, 32'h1);
        step();
        bus_idle();
    endtask

    task automatic test_random();
        logic [7:0] keys [4];
        int bias;
        int r;
        keys[0] = 8'h00; keys[1] = 8'h1C; keys[2] = 8'h1D; keys[3] = 8'h29;
        bias = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) bias = (i % 600 == 0) ? 10 : ((i % 400 == 0) ? 90 : 50);
            r = $urandom_range(0, 99);
            if (r < 8) bus_wr(2'd0, {$urandom, keys[$urandom_range(0, 3)]});
            else if (r < 10) bus_wr(2'd2, 32'($urandom_range(0, 3) != 0));
            else if (r < 13) bus_wr(2'd1, $urandom);
            else if (r < 15) bus_wr(2'd3, $urandom);
            else if (r < 25) bus_rd(2'($urandom_range(0, 3)));
            else if (r < 28) begin
                bus_wr(2'd0, 32'h1D);
                chipselect = 1'b0;
            end else bus_idle();
            evt_ready = ($urandom_range(0, 99) < bias);
            #1;
            n_vec++;
            if (readdata !== exp_rd(address)) begin
                n_fail++;
                $display("FAIL rand_read i=%0d addr=%0d got %h want %h", i, address, readdata, exp_rd(address));
            end
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL rand_model i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        bus_wr(2'd0, 32'h29);
        step();
        bus_idle();
        repeat (12) step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({evt_valid, evt_key, evt_repeat, held_key} !== 18'd0) begin
            n_fail++;
            $display("FAIL midrst_outs got %h want %h", {evt_valid, evt_key, evt_repeat, held_key}, 18'd0);
        end
        address = 2'd1; #1; n_vec++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL midrst_status got %h want %h", readdata, 32'd0); end
        address = 2'd0;
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            n_vec++;
            if ({evt_valid, evt_key, evt_repeat, held_key} !== exp_out()) begin
                n_fail++;
                $display("FAIL midrst_after i=%0d got %h want %h", i, {evt_valid, evt_key, evt_repeat, held_key}, exp_out());
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        evt_ready = 1'b0;
        bus_idle();
        model_reset();
        test_reset();
        test_press();
        test_overflow();
        test_same_key();
        test_override();
        test_no_repeat();
        test_full_pop_push();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
